// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush steering for the 5-stage core.
// Also carries saturating performance counters for stall and flush cycles.
module id_ex_stage_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard,
  input  logic              branch_taken,
  input  logic              ex_busy,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1v,
  input  logic [XLEN-1:0]   id_rs2v,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rdi,
  input  logic              id_is_regwrite,
  input  logic              id_is_legal,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1v,
  output logic [XLEN-1:0]   ex_rs2v,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rdi,
  output logic              ex_is_regwrite,
  output logic              ex_is_legal,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_FLUSH
  } mode_e;

  mode_e mode;
  logic  hazard_q;

  // A hazard reported against an empty ID slot is meaningless, so ignore it.
  assign hazard_q = hazard & id_valid;

  always_comb begin
    mode = MODE_RUN;
    if (branch_taken)  mode = MODE_FLUSH;
    else if (ex_busy)  mode = MODE_HOLD;
    else if (hazard_q) mode = MODE_BUBBLE;
  end

  // Fetch-side enables are combinational and held low throughout reset.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    if (rst_n) begin
      unique case (mode)
        MODE_FLUSH: begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
        end
        MODE_RUN: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1v        <= '0;
      ex_rs2v        <= '0;
      ex_imm         <= '0;
      ex_rdi         <= '0;
      ex_is_regwrite <= 1'b0;
      ex_is_legal    <= 1'b0;
      ex_is_load     <= 1'b0;
      ex_ctrl        <= '0;
    end else begin
      unique case (mode)
        MODE_FLUSH, MODE_BUBBLE: begin
          ex_valid       <= 1'b0;
          ex_pc          <= '0;
          ex_rs1v        <= '0;
          ex_rs2v        <= '0;
          ex_imm         <= '0;
          ex_rdi         <= '0;
          ex_is_regwrite <= 1'b0;
          ex_is_legal    <= 1'b0;
          ex_is_load     <= 1'b0;
          ex_ctrl        <= '0;
        end
        MODE_HOLD: ;
        default: begin
          ex_valid       <= id_valid;
          ex_pc          <= id_pc;
          ex_rs1v        <= id_rs1v;
          ex_rs2v        <= id_rs2v;
          ex_imm         <= id_imm;
          ex_rdi         <= id_rdi;
          ex_is_regwrite <= id_is_regwrite & id_valid;
          ex_is_legal    <= id_is_legal & id_valid;
          ex_is_load     <= id_is_load & id_valid;
          ex_ctrl        <= id_ctrl;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode == MODE_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if ((mode == MODE_HOLD || mode == MODE_BUBBLE) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; counters narrowed to 4 bits to reach saturation.
module tb_id_ex_stage_reg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hazard, branch_taken, ex_busy, id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1v, id_rs2v, id_imm;
  logic [4:0]        id_rdi;
  logic              id_is_regwrite, id_is_legal, id_is_load;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1v, ex_rs2v, ex_imm;
  logic [4:0]        ex_rdi;
  logic              ex_is_regwrite, ex_is_legal, ex_is_load;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              pc_we, ifid_we, ifid_flush;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .ex_busy(ex_busy), .id_valid(id_valid), .id_pc(id_pc), .id_rs1v(id_rs1v),
    .id_rs2v(id_rs2v), .id_imm(id_imm), .id_rdi(id_rdi),
    .id_is_regwrite(id_is_regwrite), .id_is_legal(id_is_legal),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1v(ex_rs1v), .ex_rs2v(ex_rs2v), .ex_imm(ex_imm),
    .ex_rdi(ex_rdi), .ex_is_regwrite(ex_is_regwrite), .ex_is_legal(ex_is_legal),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hazard = 1'b0; branch_taken = 1'b0; ex_busy = 1'b0;
    id_valid = 1'b1; id_pc = 32'h100; id_rs1v = 32'h11; id_rs2v = 32'h22;
    id_imm = 32'h33; id_rdi = 5'd1; id_is_regwrite = 1'b1; id_is_legal = 1'b1;
    id_is_load = 1'b0; id_ctrl = 16'hA5A5;

    // Reset held across clock edges
    tick(); tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_ifid_we", 32'(ifid_we), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("run_pc_we", 32'(pc_we), 32'd1);
    chk("run_ifid_flush", 32'(ifid_flush), 32'd0);
    tick();
    chk("first_ex_pc", ex_pc, 32'h100);
    chk("first_ex_valid", 32'(ex_valid), 32'd1);
    chk("first_ex_ctrl", 32'(ex_ctrl), 32'hA5A5);
    chk("first_ex_imm", ex_imm, 32'h33);

    // Load-use: load to x5, then a dependent instruction raises hazard
    id_pc = 32'h104; id_rdi = 5'd5; id_is_load = 1'b1;
    tick();
    chk("ld_ex_is_load", 32'(ex_is_load), 32'd1);
    chk("ld_ex_rdi", 32'(ex_rdi), 32'd5);
    id_pc = 32'h108; id_rdi = 5'd6; id_is_load = 1'b0; hazard = 1'b1;
    #1;
    chk("lu_pc_we", 32'(pc_we), 32'd0);
    chk("lu_ifid_we", 32'(ifid_we), 32'd0);
    tick();
    chk("lu_ex_valid", 32'(ex_valid), 32'd0);
    chk("lu_ex_is_load", 32'(ex_is_load), 32'd0);
    chk("lu_ex_pc", ex_pc, 32'h0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    hazard = 1'b0;
    #1;
    chk("lu_resume_pc_we", 32'(pc_we), 32'd1);
    tick();
    chk("lu_resume_ex_pc", ex_pc, 32'h108);
    chk("lu_resume_ex_valid", 32'(ex_valid), 32'd1);
    chk("lu_resume_stall", 32'(stall_cnt), 32'd1);

    // Busy hold for three cycles
    id_pc = 32'h200;
    tick();
    chk("busy_pre_ex_pc", ex_pc, 32'h200);
    id_pc = 32'h204; ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_pc_we", 32'(pc_we), 32'd0);
      chk("busy_ifid_we", 32'(ifid_we), 32'd0);
      tick();
      chk("busy_ex_pc", ex_pc, 32'h200);
    end
    chk("busy_stall_cnt", 32'(stall_cnt), 32'd4);
    ex_busy = 1'b0;
    tick();
    chk("busy_release_ex_pc", ex_pc, 32'h204);

    // Flush outranks busy and hazard
    branch_taken = 1'b1; ex_busy = 1'b1; hazard = 1'b1; id_pc = 32'h208;
    #1;
    chk("fl_ifid_flush", 32'(ifid_flush), 32'd1);
    chk("fl_pc_we", 32'(pc_we), 32'd1);
    chk("fl_ifid_we", 32'(ifid_we), 32'd1);
    tick();
    chk("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk("fl_ex_pc", ex_pc, 32'h0);
    chk("fl_ex_regwrite", 32'(ex_is_regwrite), 32'd0);
    chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fl_stall_cnt", 32'(stall_cnt), 32'd4);

    // Invalid ID slot: hazard ignored, flags gated, data still captured
    branch_taken = 1'b0; ex_busy = 1'b0; hazard = 1'b1;
    id_valid = 1'b0; id_is_regwrite = 1'b1; id_is_legal = 1'b1; id_pc = 32'h300;
    #1;
    chk("inv_pc_we", 32'(pc_we), 32'd1);
    tick();
    chk("inv_ex_regwrite", 32'(ex_is_regwrite), 32'd0);
    chk("inv_ex_legal", 32'(ex_is_legal), 32'd0);
    chk("inv_ex_valid", 32'(ex_valid), 32'd0);
    chk("inv_ex_pc", ex_pc, 32'h300);
    chk("inv_stall_cnt", 32'(stall_cnt), 32'd4);

    // Saturation: 20 busy cycles on a 4-bit counter starting at 4
    hazard = 1'b0; id_valid = 1'b1; ex_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_flush_cnt", 32'(flush_cnt), 32'd1);

    // Asynchronous reset mid-stall clears immediately
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_flush", 32'(flush_cnt), 32'd0);
    chk("mid_rst_ex_pc", ex_pc, 32'h0);
    chk("mid_rst_pc_we", 32'(pc_we), 32'd0);
    tick();
    rst_n = 1'b1; ex_busy = 1'b0; id_pc = 32'h400;
    tick();
    chk("post_rst_ex_pc", ex_pc, 32'h400);
    chk("post_rst_ex_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register plus stall/flush control for the 5-stage core. It latches decode-stage outputs into the EX stage. Its registered rd index, regwrite, legal and load flags drive the hazard detector's stage-0 inputs. It consumes the detector's hazard output, the EX branch-redirect and the EX multi-cycle busy signal, then issues PC/IF-ID write enables, IF/ID flush and bubble insertion. Saturating stall/flush performance counters are included.

Parameters:
XLEN, 32, datapath width of pc/operand/imm fields
CTRL_W, 16, width of opaque decoded control bundle passed to EX
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
hazard  input  1  load-use hazard from hazard detector (combinational)
branch_taken  input  1  EX-stage redirect; flushes younger stages
ex_busy  input  1  EX multi-cycle unit not ready; freeze pipeline
id_valid  input  1  ID stage holds a real instruction
id_pc  input  XLEN  pc of ID instruction
id_rs1v  input  XLEN  rs1 operand value
id_rs2v  input  XLEN  rs2 operand value
id_imm  input  XLEN  decoded immediate
id_rdi  input  5  destination register index
id_is_regwrite  input  1  instruction writes rd
id_is_legal  input  1  instruction decoded legally
id_is_load  input  1  instruction is a load (hazard-producing)
id_ctrl  input  CTRL_W  decoded control bundle
ex_valid  output  1  EX holds a real instruction
ex_pc, ex_rs1v, ex_rs2v, ex_imm  output  XLEN each  registered copies
ex_rdi  output  5  to hazard detector rdi_0
ex_is_regwrite  output  1  to hazard detector is_regwrite_0
ex_is_legal  output  1  to hazard detector is_legal_0
ex_is_load  output  1  to hazard detector is_hazard_0
ex_ctrl  output  CTRL_W  registered control bundle
pc_we  output  1  PC register write enable
ifid_we  output  1  IF/ID register write enable
ifid_flush  output  1  IF/ID register clear to bubble
stall_cnt  output  CNT_W  cycles lost to hazard or ex_busy, saturating
flush_cnt  output  CNT_W  number of branch flushes, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs 0 (bubble), counters 0. pc_we, ifid_we and ifid_flush are forced 0 while rst_n is low.
- Per cycle, mode is decided by strict priority, using hazard_q = hazard & id_valid:
  1 FLUSH (branch_taken): ID/EX loads a bubble (ex_valid, ex_is_regwrite, ex_is_legal, ex_is_load = 0; data fields 0). pc_we=1, ifid_we=1, ifid_flush=1. flush_cnt+1.
  2 HOLD (ex_busy, no branch_taken): ID/EX retains all fields. pc_we=0, ifid_we=0, ifid_flush=0. stall_cnt+1.
  3 BUBBLE (hazard_q, no 1/2): ID/EX loads a bubble. pc_we=0, ifid_we=0, ifid_flush=0. stall_cnt+1.
  4 RUN: ID/EX captures all id_* fields; ex_valid = id_valid. pc_we=1, ifid_we=1, ifid_flush=0.
- Control outputs are combinational from current inputs, with zero-cycle latency. Data capture has 1-cycle latency.
- When id_valid=0 in RUN, the captured flags are gated: ex_is_regwrite, ex_is_legal and ex_is_load are written 0.
- A load-use pair gives exactly one BUBBLE cycle. After the bubble, ex_is_load=0, so the detector deasserts.
- branch_taken together with ex_busy resolves as FLUSH; the redirect has priority.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush clears everything immediately. The first cycle after release behaves as RUN from an empty EX.

Test Plan:
- Reset: assert rst_n=0 with id_valid=1 and clk running -> all ex_* outputs 0, pc_we=0; release -> next edge captures id_pc=0x100 into ex_pc, ex_valid=1.
- Load-use: cycle n captures a load with rdi=5 and ex_is_load=1; cycle n+1 has hazard=1 -> pc_we=0, ifid_we=0, ex_valid=0 at n+2, stall_cnt=1; hazard drops -> instruction captured at n+3.
- Busy hold: ex_busy=1 for 3 cycles with ex_pc=0x200 -> ex_pc stays 0x200, pc_we=0 throughout, stall_cnt=3.
- Flush priority: branch_taken=1, ex_busy=1 and hazard=1 in the same cycle -> ifid_flush=1, pc_we=1, bubble in EX, flush_cnt=1, stall_cnt unchanged.
- Invalid ID: id_valid=0, hazard=1, id_is_regwrite=1 -> RUN mode, ex_is_regwrite=0, stall_cnt unchanged.
- Saturation: CNT_W=4, hold ex_busy=1 for 20 cycles -> stall_cnt ends at 15.
